// File: rtl/wb_mux_pipe.sv
// Registered writeback-select stage: picks one of NUM_SRC results, holds it with its
// destination for the RegFile write port, and keeps the last committed value for forwarding.
module wb_mux_pipe #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  input  logic [SEL_W-1:0]         InSel,
  input  logic [NUM_SRC*WIDTH-1:0] InData,
  input  logic [ADDR_W-1:0]        InDest,
  input  logic                     Stall,
  input  logic                     Flush,
  output logic                     OutValid,
  output logic [WIDTH-1:0]         OutData,
  output logic [ADDR_W-1:0]        OutDest,
  output logic                     WrEn,
  output logic [WIDTH-1:0]         LastData,
  output logic [ADDR_W-1:0]        LastDest,
  output logic                     LastValid,
  output logic                     SelErr,
  output logic [7:0]               ErrCount
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]    last_data_q, last_data_d;
  logic [ADDR_W-1:0]   last_dest_q, last_dest_d;
  logic                last_valid_q, last_valid_d;
  logic                sel_err_q, sel_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [31:0]         sel_ext;
  logic                sel_legal;
  logic [WIDTH-1:0]    sel_data;

  // With a power-of-two source count every select value is in range.
  assign sel_ext   = 32'(InSel);
  assign sel_legal = (sel_ext < 32'(NUM_SRC));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_ext == 32'(i)) sel_data = InData[i*WIDTH +: WIDTH];
    end
  end

  assign WrEn = (state_q == FULL) && !Stall;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    dest_d       = dest_q;
    last_data_d  = last_data_q;
    last_dest_d  = last_dest_q;
    last_valid_d = last_valid_q;
    sel_err_d    = sel_err_q;
    err_cnt_d    = err_cnt_q;

    if (WrEn) begin
      last_data_d  = data_q;
      last_dest_d  = dest_q;
      last_valid_d = 1'b1;
    end

    // Flush wins over stall and skips the select check; a stall freezes everything.
    if (Flush) begin
      state_d = EMPTY;
    end else if (!Stall) begin
      state_d = EMPTY;
      if (InValid && sel_legal) begin
        state_d = FULL;
        data_d  = sel_data;
        dest_d  = InDest;
      end else if (InValid) begin
        sel_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      dest_q       <= '0;
      last_data_q  <= '0;
      last_dest_q  <= '0;
      last_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      last_data_q  <= last_data_d;
      last_dest_q  <= last_dest_d;
      last_valid_q <= last_valid_d;
      sel_err_q    <= sel_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign OutValid  = (state_q == FULL);
  assign OutData   = data_q;
  assign OutDest   = dest_q;
  assign LastData  = last_data_q;
  assign LastDest  = last_dest_q;
  assign LastValid = last_valid_q;
  assign SelErr    = sel_err_q;
  assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Bench for wb_mux_pipe: a default instance (8b/3 sources) and a 16b/5-source instance,
// both checked every cycle against a rule-level model of the stage.
module tb_wb_mux_pipe;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [31:0] dest;
    logic        lvalid;
    logic [31:0] ldata;
    logic [31:0] ldest;
    logic        err;
    int          cnt;
  } model_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  // Instance A: WIDTH=8, NUM_SRC=3, ADDR_W=4
  logic        InValidA = 0, StallA = 0, FlushA = 0;
  logic [1:0]  InSelA = 0;
  logic [3:0]  InDestA = 0;
  logic [7:0]  srcA [3];
  logic [23:0] InDataA;
  logic        OutValidA, WrEnA, LastValidA, SelErrA;
  logic [7:0]  OutDataA, LastDataA, ErrCountA;
  logic [3:0]  OutDestA, LastDestA;

  // Instance B: WIDTH=16, NUM_SRC=5, ADDR_W=3
  logic        InValidB = 0, StallB = 0, FlushB = 0;
  logic [2:0]  InSelB = 0;
  logic [2:0]  InDestB = 0;
  logic [15:0] srcB [5];
  logic [79:0] InDataB;
  logic        OutValidB, WrEnB, LastValidB, SelErrB;
  logic [15:0] OutDataB, LastDataB;
  logic [7:0]  ErrCountB;
  logic [2:0]  OutDestB, LastDestB;

  assign InDataA = {srcA[2], srcA[1], srcA[0]};
  assign InDataB = {srcB[4], srcB[3], srcB[2], srcB[1], srcB[0]};

  wb_mux_pipe #(.WIDTH(8), .NUM_SRC(3), .ADDR_W(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .InValid(InValidA), .InSel(InSelA), .InData(InDataA),
    .InDest(InDestA), .Stall(StallA), .Flush(FlushA), .OutValid(OutValidA),
    .OutData(OutDataA), .OutDest(OutDestA), .WrEn(WrEnA), .LastData(LastDataA),
    .LastDest(LastDestA), .LastValid(LastValidA), .SelErr(SelErrA), .ErrCount(ErrCountA));

  wb_mux_pipe #(.WIDTH(16), .NUM_SRC(5), .ADDR_W(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .InValid(InValidB), .InSel(InSelB), .InData(InDataB),
    .InDest(InDestB), .Stall(StallB), .Flush(FlushB), .OutValid(OutValidB),
    .OutData(OutDataB), .OutDest(OutDestB), .WrEn(WrEnB), .LastData(LastDataB),
    .LastDest(LastDestB), .LastValid(LastValidB), .SelErr(SelErrB), .ErrCount(ErrCountB));

  int     n_checks = 0;
  int     n_fail   = 0;
  model_t mA, mB;
  logic [7:0] commits [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.valid = 0; m.data = 0; m.dest = 0; m.lvalid = 0;
    m.ldata = 0; m.ldest = 0; m.err = 0; m.cnt = 0;
    return m;
  endfunction

  // One clock edge of the stage, straight from its behavioural rules.
  function automatic model_t step(model_t m, bit v, int sel, int ns, logic [31:0] d,
                                  logic [31:0] dest, bit stall, bit flush);
    model_t n = m;
    if (m.valid && !stall) begin
      n.lvalid = 1; n.ldata = m.data; n.ldest = m.dest;
    end
    if (flush) n.valid = 0;
    else if (!stall) begin
      if (!v) n.valid = 0;
      else if (sel < ns) begin
        n.valid = 1; n.data = d; n.dest = dest;
      end else begin
        n.valid = 0; n.err = 1;
        if (n.cnt < 255) n.cnt++;
      end
    end
    return n;
  endfunction

  task automatic check_all();
    check("A_valid", 32'(OutValidA), 32'(mA.valid));
    check("A_data", 32'(OutDataA), mA.data);
    check("A_dest", 32'(OutDestA), mA.dest);
    check("A_wren", 32'(WrEnA), 32'(mA.valid && !StallA));
    check("A_lvalid", 32'(LastValidA), 32'(mA.lvalid));
    check("A_ldata", 32'(LastDataA), mA.ldata);
    check("A_ldest", 32'(LastDestA), mA.ldest);
    check("A_selerr", 32'(SelErrA), 32'(mA.err));
    check("A_errcnt", 32'(ErrCountA), 32'(mA.cnt));
    check("B_valid", 32'(OutValidB), 32'(mB.valid));
    check("B_data", 32'(OutDataB), mB.data);
    check("B_dest", 32'(OutDestB), mB.dest);
    check("B_wren", 32'(WrEnB), 32'(mB.valid && !StallB));
    check("B_lvalid", 32'(LastValidB), 32'(mB.lvalid));
    check("B_ldata", 32'(LastDataB), mB.ldata);
    check("B_ldest", 32'(LastDestB), mB.ldest);
    check("B_selerr", 32'(SelErrB), 32'(mB.err));
    check("B_errcnt", 32'(ErrCountB), 32'(mB.cnt));
  endtask

  // Called at posedge+1 after inputs are set: check, advance model and DUT one edge.
  task automatic tick();
    model_t nA, nB;
    logic [31:0] dA, dB;
    #1;
    check_all();
    dA = (int'(InSelA) < 3) ? 32'(srcA[InSelA]) : 32'h0;
    dB = (int'(InSelB) < 5) ? 32'(srcB[InSelB]) : 32'h0;
    nA = step(mA, InValidA, int'(InSelA), 3, dA, 32'(InDestA), StallA, FlushA);
    nB = step(mB, InValidB, int'(InSelB), 5, dB, 32'(InDestB), StallB, FlushB);
    if (WrEnA) commits.push_back(OutDataA);
    @(posedge Clk);
    mA = nA;
    mB = nB;
    #1;
  endtask

  task automatic drive_a(input bit v, input int sel, input int dest, input bit stall, input bit flush);
    InValidA = v; InSelA = 2'(sel); InDestA = 4'(dest); StallA = stall; FlushA = flush;
  endtask

  initial begin
    srcA[0] = 8'h11; srcA[1] = 8'h22; srcA[2] = 8'h33;
    for (int i = 0; i < 5; i++) srcB[i] = 16'(i * 16'h1111);
    mA = model_reset();
    mB = model_reset();

    // Reset values and WrEn held low during reset
    #1 Reset = 1'b0;
    #2;
    check_all();
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Basic select
    drive_a(1, 1, 5, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("basic_valid", 32'(OutValidA), 32'h1);
    check("basic_data", 32'(OutDataA), 32'h22);
    check("basic_dest", 32'(OutDestA), 32'h5);
    tick();
    check("basic_last", 32'(LastDataA), 32'h22);
    tick();

    // Stream with stall holding 0x33
    commits.delete();
    drive_a(1, 0, 1, 0, 0); tick();
    drive_a(1, 2, 2, 0, 0); tick();
    drive_a(1, 0, 3, 1, 0); tick();
    check("stall_hold", 32'(OutDataA), 32'h33);
    tick();
    drive_a(1, 0, 3, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0); tick();
    tick();
    check("commit_count", 32'(commits.size()), 32'd3);
    if (commits.size() == 3) begin
      check("commit0", 32'(commits[0]), 32'h11);
      check("commit1", 32'(commits[1]), 32'h33);
      check("commit2", 32'(commits[2]), 32'h11);
    end

    // Illegal select, then saturation
    drive_a(1, 3, 7, 0, 0); tick();
    check("illegal_valid", 32'(OutValidA), 32'h0);
    check("illegal_err", 32'(SelErrA), 32'h1);
    check("illegal_cnt", 32'(ErrCountA), 32'd1);
    check("illegal_hold", 32'(OutDataA), 32'h11);
    for (int i = 0; i < 300; i++) begin
      srcA[0] = 8'($urandom);
      drive_a(1, 3, int'($urandom_range(0, 15)), 0, 0);
      tick();
    end
    check("err_saturate", 32'(ErrCountA), 32'd255);

    // Flush priority over stall, then flush without stall
    srcA[0] = 8'h5A;
    drive_a(1, 0, 9, 0, 0); tick();
    drive_a(1, 1, 4, 1, 1); tick();
    check("flush_stall_valid", 32'(OutValidA), 32'h0);
    check("flush_stall_nocommit", 32'(LastDataA), 32'h11);
    drive_a(1, 0, 9, 0, 0); tick();
    drive_a(1, 2, 4, 0, 1); tick();
    check("flush_commit", 32'(LastDataA), 32'h5A);
    check("flush_empty", 32'(OutValidA), 32'h0);
    drive_a(0, 0, 0, 0, 0);

    // Illegal selects on the 5-source instance
    for (int s = 5; s < 8; s++) begin
      InValidB = 1; InSelB = 3'(s); InDestB = 3'(s);
      tick();
    end
    InValidB = 0;
    check("B_illegal_err", 32'(SelErrB), 32'h1);
    check("B_illegal_cnt", 32'(ErrCountB), 32'd3);

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) srcA[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) srcB[i] = 16'($urandom);
      drive_a($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      InValidB = ($urandom_range(0, 3) != 0);
      InSelB   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      InDestB  = 3'($urandom);
      StallB   = ($urandom_range(0, 4) == 0);
      FlushB   = ($urandom_range(0, 9) == 0);
      tick();
    end

    // Async reset while FULL
    drive_a(1, 1, 6, 0, 0);
    InValidB = 0; StallB = 0; FlushB = 0;
    tick();
    drive_a(0, 0, 0, 0, 0);
    check("pre_rst_full", 32'(OutValidA), 32'h1);
    Reset = 1'b0;
    #1;
    check("rst_valid", 32'(OutValidA), 32'h0);
    check("rst_wren", 32'(WrEnA), 32'h0);
    check("rst_selerr", 32'(SelErrA), 32'h0);
    check("rst_errcnt", 32'(ErrCountA), 32'h0);
    check("rst_lvalid", 32'(LastValidA), 32'h0);
    mA = model_reset();
    mB = model_reset();
    check_all();
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("post_rst_lvalid", 32'(LastValidA), 32'h0);
    drive_a(1, 2, 3, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0); tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_mux_pipe.md
# wb_mux_pipe

Parametrised, registered writeback-select stage for the 3BC processor datapath. It selects one of `NUM_SRC` result sources (data memory, ALU, immediate, and additional sources) and registers the selected value with its destination register address. It supports stall, flush, illegal-select detection and a last-committed-value holding register for forwarding. It sits between the execute/memory stage and the RegFile write port.

## Interface
- `WIDTH`, default 8: data width of each source and of the output.
- `NUM_SRC`, default 3: number of sources; legal range 2..16.
- `ADDR_W`, default 4: destination register address width.
- `SEL_W`, default `$clog2(NUM_SRC)`: derived select width; not overridden.

Ports:
- `Clk`, input, 1: single clock. All state updates on the rising edge.
- `Reset`, input, 1: reset is asynchronous and active-low.
- `InValid`, input, 1: input bundle present this cycle.
- `InSel`, input, `SEL_W`: source index.
- `InData`, input, `NUM_SRC*WIDTH`: packed sources; source i is at `[i*WIDTH +: WIDTH]`.
- `InDest`, input, `ADDR_W`: destination register address.
- `Stall`, input, 1: downstream hold.
- `Flush`, input, 1: discard the stage contents.
- `OutValid`, output, 1: stage holds a valid writeback.
- `OutData`, output, `WIDTH`: registered selected data.
- `OutDest`, output, `ADDR_W`: registered destination.
- `WrEn`, output, 1: RegFile write enable; combinational, `OutValid & ~Stall`.
- `LastData`, output, `WIDTH`: data of the most recent commit.
- `LastDest`, output, `ADDR_W`: destination of the most recent commit.
- `LastValid`, output, 1: at least one commit has occurred since reset.
- `SelErr`, output, 1: sticky flag, set on an illegal select.
- `ErrCount`, output, 8: count of illegal selects, saturating at 255.

## Operation
- The stage is a single register with two states, EMPTY (`OutValid`=0) and FULL (`OutValid`=1).
- **Commit:** a commit occurs in any cycle with `WrEn`=1. On that edge, `LastData`/`LastDest` take `OutData`/`OutDest` and `LastValid` is set to 1.
- **Load:** the stage loads when `Stall`=0, `Flush`=0 and `InValid`=1. `OutData` takes `InData[InSel]`, `OutDest` takes `InDest`, and the stage goes to FULL.
  - If `InSel` is 0..`NUM_SRC`-1, the load proceeds as above.
  - If `InSel` >= `NUM_SRC` (illegal), nothing is loaded. The stage goes to EMPTY, `OutData`/`OutDest` are held, `SelErr` is set to 1, and `ErrCount` increments unless it is already at 255.
- If `Stall`=0, `Flush`=0 and `InValid`=0, the stage goes to EMPTY and `OutData`/`OutDest` are held.
- **Stall:** while `Stall`=1 (and `Flush`=0), all stage registers hold. `InValid`/`InSel` are ignored and no error is recorded. Upstream must hold its bundle.
- **Flush:** `Flush` has the highest priority. `OutValid` goes to 0 on the next edge regardless of `Stall` or `InValid`. The input is not loaded and is not checked for an illegal select.
- With `Flush`=1 and `Stall`=0, a FULL stage still commits in that cycle, because `WrEn` is 1.
- `SelErr`, `ErrCount`, `LastData`, `LastDest` and `LastValid` are cleared only by `Reset`. `Flush` does not touch them.
- When `NUM_SRC` is a power of two, no select value is illegal, and `SelErr`/`ErrCount` stay 0.

## Timing
- Latency is one cycle: a bundle loaded at edge N appears on `OutData`/`OutValid` after edge N.
- Throughput is one bundle per cycle when `Stall`=0: back-to-back loads with a commit every cycle.
- `LastData` reflects a commit one cycle after `WrEn`.
- Reset values, applied asynchronously on assertion:
  - `OutValid`=0, `OutData`=0, `OutDest`=0
  - `LastData`=0, `LastDest`=0, `LastValid`=0
  - `SelErr`=0, `ErrCount`=0
- `WrEn`=0 during reset.
- Reset mid-operation: a pending FULL entry is discarded with no commit.
- Deassertion is sampled by the first rising edge after `Reset` goes high.

## Test plan
- **Basic select:** reset, then WIDTH=8/NUM_SRC=3, sources {0x11,0x22,0x33}, `InSel`=1, `InDest`=5, `InValid`=1 → next cycle `OutValid`=1, `OutData`=0x22, `OutDest`=5, `WrEn`=1. One cycle later `LastData`=0x22, `LastValid`=1.
- **Stream with stall:** `InSel` 0,2,0 on consecutive cycles, with `Stall`=1 for two cycles while holding 0x33 → `OutData` holds 0x33 and `WrEn`=0 for those two cycles. Exactly three commits in order 0x11, 0x33, 0x11.
- **Illegal select:** `InSel`=3 with NUM_SRC=3 → `OutValid`=0, `SelErr`=1, `ErrCount`=1. Previous `OutData` is held. 300 further illegal selects → `ErrCount`=255.
- **Flush priority:** FULL stage with `Stall`=1, `Flush`=1, `InValid`=1 → next cycle `OutValid`=0, no commit, `LastData` unchanged. Repeat with `Stall`=0 → one commit that cycle, then EMPTY.
- **Async reset mid-op:** assert `Reset`=0 between edges while FULL → `OutValid`, `WrEn`, `SelErr` and `ErrCount` go to 0 immediately, with no commit.
- **Parameter sweep:** WIDTH=16/NUM_SRC=5/ADDR_W=3, random legal selects → `OutData` equals the selected slice every cycle. `InSel`=5..7 → flagged as illegal.
